// File: rtl/serial_mag_compare_ctrl_if.sv
// Request/result bundle for the bit-serial magnitude comparator controller.
interface serial_mag_compare_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             g;
  logic             e;
  logic             l;

  modport master (
    output start, a, b,
    input  busy, done, g, e, l
  );

  modport slave (
    input  start, a, b,
    output busy, done, g, e, l
  );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial MSB-first magnitude comparator controller with early exit and
// a registered one-hot g/e/l result plus a one-cycle done pulse.
module serial_mag_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_mag_compare_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_t;

  state_t            state;
  logic [WIDTH-1:0]  sa;
  logic [WIDTH-1:0]  sb;
  logic [CntW-1:0]   cnt;
  logic              busy_r;
  logic              done_r;
  logic [2:0]        gel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= StIdle;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      gel    <= 3'b000;
    end else begin
      case (state)
        StIdle: begin
          done_r <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            cnt    <= CntW'(WIDTH - 1);
            busy_r <= 1'b1;
            state  <= StCompare;
          end
        end
        StCompare: begin
          // Only the MSB pair is examined; equal bits shift the next pair up.
          if (sa[WIDTH-1] == sb[WIDTH-1]) begin
            if (cnt != '0) begin
              sa  <= sa << 1;
              sb  <= sb << 1;
              cnt <= cnt - 1'b1;
            end else begin
              gel    <= 3'b010;
              done_r <= 1'b1;
              state  <= StDone;
            end
          end else begin
            gel    <= sa[WIDTH-1] ? 3'b100 : 3'b001;
            done_r <= 1'b1;
            state  <= StDone;
          end
        end
        StDone: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= StIdle;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.g    = gel[2];
  assign bus.e    = gel[1];
  assign bus.l    = gel[0];
endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench for serial_mag_compare_ctrl with a cycle-level reference model.
module tb_serial_mag_compare_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_mag_compare_ctrl_if #(.WIDTH(W)) bus ();

  serial_mag_compare_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare cycles: W - (index of highest differing bit), or W when equal.
  function automatic int lat_f(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return W - i;
    end
    return W;
  endfunction

  function automatic logic [2:0] cmp_f(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // Model: m_rem counts remaining busy cycles (compare cycles + the done cycle).
  int         m_rem;
  logic       m_done;
  logic [2:0] m_res;
  logic [2:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= 3'b000;
      m_pend <= 3'b000;
    end else if (m_rem == 0) begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_rem  <= lat_f(bus.a, bus.b) + 1;
        m_pend <= cmp_f(bus.a, bus.b);
      end
    end else begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 2);
      if (m_rem == 2) m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_busy", {31'b0, bus.busy}, {31'b0, m_rem != 0});
      check("model_done", {31'b0, bus.done}, {31'b0, m_done});
      check("model_gel", {29'b0, bus.g, bus.e, bus.l}, {29'b0, m_res});
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input int exp_lat, input logic [2:0] exp_res, input bit second_req);
    int done_at;
    int busy_n;
    int done_n;
    done_at = -1;
    busy_n  = 0;
    done_n  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = va;
    bus.b     = vb;
    for (int j = 0; j < int'(W) + 4; j++) begin
      @(negedge clk);
      // Index j is the cycle after edge E(j).
      if (j == 0) begin
        bus.start = second_req;
        if (second_req) begin
          bus.a = 8'h00;
          bus.b = 8'hFF;
        end
      end
      if (j == 1) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = j;
          check({name, "_gel"}, {29'b0, bus.g, bus.e, bus.l}, {29'b0, exp_res});
        end
      end
    end
    check({name, "_lat"}, done_at, exp_lat);
    check({name, "_ndone"}, done_n, 1);
    check({name, "_busy"}, busy_n, exp_lat + 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_done", {31'b0, bus.done}, 0);
    check("rst_gel", {29'b0, bus.g, bus.e, bus.l}, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    run_op("equal", 8'hA5, 8'hA5, 8, 3'b010, 1'b0);

    // Asynchronous reset between edges clears a held result.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_gel", {29'b0, bus.g, bus.e, bus.l}, 0);
    check("midrst_busy", {31'b0, bus.busy}, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    run_op("msb", 8'h80, 8'h7F, 1, 3'b100, 1'b0);
    run_op("lsb", 8'h12, 8'h13, 8, 3'b001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_gel", {29'b0, bus.g, bus.e, bus.l}, 32'b001);
    end

    run_op("busyprot", 8'h40, 8'h20, 2, 3'b100, 1'b1);

    // Abort a running compare after E4.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h3C;
    bus.b     = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 0);
    check("abort_done", {31'b0, bus.done}, 0);
    check("abort_gel", {29'b0, bus.g, bus.e, bus.l}, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_nodone", {31'b0, bus.done}, 0);
    end

    run_op("after_abort", 8'h01, 8'h02, 7, 3'b001, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_mag_compare_ctrl.md
# serial_mag_compare_ctrl

Bit-serial N-bit magnitude comparator controller. It captures two WIDTH-bit operands on a start handshake and steps a single 1-bit greater/equal/less compare stage over them, MSB first, one bit per clock. It terminates early at the first differing bit and presents a registered one-hot g/e/l result with a one-cycle done pulse. It is the sequencing layer that lets the 1-bit comparator datapath serve wide operands in the comparator family.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- a  input  WIDTH  operand A; sampled only on the accept edge.
- b  input  WIDTH  operand B; sampled only on the accept edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- g  output  1  registered result: a > b.
- e  output  1  registered result: a == b.
- l  output  1  registered result: a < b.

## Operation
- State machine has three states:
  - IDLE: waits for a request.
  - COMPARE: runs the bit-serial compare.
  - DONE: presents the result for one cycle.
- IDLE to COMPARE on `start`=1. On that edge:
  - load `a` and `b` into internal shift registers;
  - load the bit counter with WIDTH-1.
- COMPARE: each cycle the 1-bit stage compares the current MSB pair (sa, sb):
  - sa == sb and counter > 0: shift both registers left by 1, decrement the counter, stay in COMPARE.
  - sa == sb and counter == 0: register {g,e,l}=3'b010, go to DONE.
  - sa=1, sb=0: register {g,e,l}=3'b100, go to DONE (early exit).
  - sa=0, sb=1: register {g,e,l}=3'b001, go to DONE (early exit).
- DONE: `done`=1 for exactly this cycle, then return unconditionally to IDLE.
- `start` is ignored in COMPARE and DONE. It is not queued.
- `a` and `b` changing after the accept edge have no effect on the running compare.
- `g`, `e`, `l` are one-hot once the first compare completes. They hold their value until the next result is written, including through IDLE and across new starts.
- Bit counter width is clog2(WIDTH). The counter never wraps: reaching 0 always terminates.

## Timing
- Reset values, applied asynchronously on `rst`=1:
  - state = IDLE;
  - `busy`=0, `done`=0;
  - `g`=`e`=`l`=0;
  - shift registers and counter = 0.
- Reset is released synchronously to `clk` by the environment. The first accept is possible on the first rising edge with `rst`=0.
- Accept edge is E0. Let k be the index of the highest differing bit.
  - Result and DONE state register at edge E(WIDTH-k).
  - For equal operands, they register at edge E(WIDTH).
  - `done` is high for the cycle after that edge.
- Latency range: minimum 1 compare cycle (MSB differs); maximum WIDTH cycles (equal, or only bit 0 differs).
- `busy` rises the cycle after E0 and falls the cycle after `done`.
- Back-to-back operation: `start` held high restarts on the edge where state is IDLE. Minimum accept-to-accept spacing is latency + 2 edges.
- Reset mid-operation (COMPARE or DONE):
  - the operation aborts immediately;
  - no `done` pulse is produced;
  - `g`/`e`/`l` clear to 0.
- `start` and `rst` high together: reset wins.

## Test plan
- Reset check: assert `rst` mid-cycle with no clock edge. Required: `busy`=`done`=`g`=`e`=`l`=0 immediately.
- Equal operands: WIDTH=8, a=8'hA5, b=8'hA5, one-cycle `start`. Required: `done` after edge E8, {g,e,l}=010, `busy` high for 9 cycles.
- MSB early exit: a=8'h80, b=8'h7F. Required: `done` after E1, {g,e,l}=100.
- LSB difference: a=8'h12, b=8'h13. Required: `done` after E8, {l}=1. Result holds 3'b001 through 5 idle cycles.
- Busy protection: start with a=8'h40, b=8'h20; at E1 drive `start`=1 with a=8'h00, b=8'hFF. Required: one `done` after E2, {g,e,l}=100, second request ignored.
- Reset abort: start with a=b=8'h3C; assert `rst` after E4. Required: no `done` pulse, outputs 0. A subsequent start with a=8'h01, b=8'h02 gives `done` after E7 with l=1.
